// File: rtl/dds_multi_wave.sv
// Multi-channel DDS: phase accumulator, offset, sine-ROM/square/triangle/saw select, amplitude scaling.
// Optional DDS_DITHER_EN adds LFSR dither ahead of phase truncation. en -> data_out latency 3 cycles, no backpressure.
module dds_multi_wave #(
  parameter int CH_NUM = 2,
  parameter int ACC_W  = 32,
  parameter int PH_W   = 12,
  parameter int DATA_W = 8,
  parameter int AMP_W  = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CH_NUM-1:0]        en,
  input  logic [CH_NUM-1:0]        clr,
  input  logic [CH_NUM*ACC_W-1:0]  freq_word,
  input  logic [CH_NUM-1:0]        freq_load,
  input  logic [CH_NUM*PH_W-1:0]   phase_off,
  input  logic [CH_NUM*2-1:0]      wave_sel,
  input  logic [CH_NUM*AMP_W-1:0]  amp,
  output logic [CH_NUM*PH_W-1:0]   rom_addr,
  input  logic [CH_NUM*DATA_W-1:0] rom_q,
  output logic [CH_NUM*DATA_W-1:0] data_out,
  output logic [CH_NUM-1:0]        data_valid,
  output logic [CH_NUM*4-1:0]      wave_lab
);

  localparam logic [1:0] SEL_SIN = 2'b11;
  localparam logic [1:0] SEL_SQU = 2'b10;
  localparam logic [1:0] SEL_TRI = 2'b01;

`ifdef DDS_DITHER_EN
  localparam int DITH_W = ((ACC_W - PH_W) < 16) ? (ACC_W - PH_W) : 16;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  logic [15:0] lfsr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr <= 16'hACE1;
    end else if (|en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  freq_act;
    logic [PH_W-1:0]   ph_tr;
    logic [PH_W-1:0]   ph_s1;
    logic [DATA_W:0]   ph_s2;
    logic              en_s1;
    logic              en_s2;
    logic [1:0]        ws_s1;
    logic [1:0]        ws_s2;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic [3:0]        lab_q;

`ifdef DDS_DITHER_EN
    logic [ACC_W-1:0] acc_tr;

    // Dither only touches the truncation path; the stored accumulator stays exact.
    always_comb begin
      acc_tr = acc + {{(ACC_W-DITH_W){1'b0}}, lfsr[DITH_W-1:0]};
      ph_tr  = acc_tr[ACC_W-1 -: PH_W];
    end
`else
    always_comb ph_tr = acc[ACC_W-1 -: PH_W];
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        freq_act <= '0;
        acc      <= '0;
      end else begin
        if (freq_load[i]) freq_act <= freq_word[i*ACC_W +: ACC_W];
        if (clr[i] || !en[i]) acc <= '0;
        else                  acc <= acc + freq_act;
      end
    end

    // ph_s2 keeps only the phase bits the arithmetic waveforms need: MSB plus triangle/saw bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        ph_s1 <= '0;
        en_s1 <= 1'b0;
        ws_s1 <= SEL_SIN;
        ph_s2 <= '0;
        en_s2 <= 1'b0;
        ws_s2 <= SEL_SIN;
      end else begin
        ph_s1 <= ph_tr + phase_off[i*PH_W +: PH_W];
        en_s1 <= en[i];
        ws_s1 <= wave_sel[i*2 +: 2];
        ph_s2 <= ph_s1[PH_W-1 -: DATA_W+1];
        en_s2 <= en_s1;
        ws_s2 <= ws_s1;
      end
    end

    always_comb begin
      raw = ph_s2[DATA_W:1];
      case (ws_s2)
        SEL_SIN: raw = rom_q[i*DATA_W +: DATA_W];
        SEL_SQU: raw = ph_s2[DATA_W] ? '0 : '1;
        SEL_TRI: raw = ph_s2[DATA_W] ? ~ph_s2[DATA_W-1:0] : ph_s2[DATA_W-1:0];
        default: raw = ph_s2[DATA_W:1];
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
        lab_q  <= 4'b1000;
      end else begin
        vld_q  <= en_s2;
        dout_q <= en_s2 ? DATA_W'(({{AMP_W{1'b0}}, raw} *
                                   {{DATA_W{1'b0}}, amp[i*AMP_W +: AMP_W]}) >> AMP_W)
                        : '0;
        case (ws_s2)
          SEL_SIN: lab_q <= 4'b1000;
          SEL_SQU: lab_q <= 4'b0100;
          SEL_TRI: lab_q <= 4'b0010;
          default: lab_q <= 4'b0001;
        endcase
      end
    end

    assign rom_addr[i*PH_W +: PH_W]     = ph_s1;
    assign data_out[i*DATA_W +: DATA_W] = dout_q;
    assign data_valid[i]                = vld_q;
    assign wave_lab[i*4 +: 4]           = lab_q;
  end

endmodule

// File: tb/tb_dds_multi_wave.sv
// Directed bench for dds_multi_wave: vector table for steady-state samples plus hand sequences
// for frequency reload, enable drop, clear, select change and mid-run reset.
module tb_dds_multi_wave;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  en, clr, freq_load;
  logic [63:0] freq_word;
  logic [23:0] phase_off;
  logic [3:0]  wave_sel;
  logic [15:0] amp;
  logic [23:0] rom_addr;
  logic [15:0] rom_q;
  logic [15:0] data_out;
  logic [1:0]  data_valid;
  logic [7:0]  wave_lab;

  int checks = 0;
  int failures = 0;

  dds_multi_wave dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .clr(clr),
    .freq_word(freq_word), .freq_load(freq_load), .phase_off(phase_off),
    .wave_sel(wave_sel), .amp(amp), .rom_addr(rom_addr), .rom_q(rom_q),
    .data_out(data_out), .data_valid(data_valid), .wave_lab(wave_lab)
  );

  always #10 sys_clk = ~sys_clk;

  // Sine ROM stand-in: one-cycle registered read, q = addr[11:4].
  always @(posedge sys_clk) begin
    for (int c = 0; c < 2; c++) rom_q[c*8 +: 8] <= rom_addr[c*12+4 +: 8];
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] freq;
    logic [11:0] off;
    logic [7:0]  amp;
    int          k;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    logic        e_vld;
    logic [3:0]  e_lab;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    en = 2'b00;
    clr = 2'b00;
    freq_load = 2'b00;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic step_addr0(input string name, input logic [11:0] exp);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk(name, rom_addr[11:0], exp);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en = '0; clr = '0; freq_load = '0;
    freq_word = '0; phase_off = '0; wave_sel = '0; amp = '0;

    vt[0]  = '{2'b00, 32'h0010_0000, 12'd0,    8'd255, 2,   12'd1,    8'h00, 1'b0, 4'b0001};
    vt[1]  = '{2'b00, 32'h0010_0000, 12'd0,    8'd255, 3,   12'd2,    8'h00, 1'b1, 4'b0001};
    vt[2]  = '{2'b00, 32'h0100_0000, 12'd0,    8'd255, 20,  12'd304,  8'd16, 1'b1, 4'b0001};
    vt[3]  = '{2'b10, 32'h0800_0000, 12'd0,    8'd255, 3,   12'd256,  8'hFE, 1'b1, 4'b0100};
    vt[4]  = '{2'b10, 32'h0800_0000, 12'd0,    8'd255, 18,  12'd2176, 8'hFE, 1'b1, 4'b0100};
    vt[5]  = '{2'b10, 32'h0800_0000, 12'd0,    8'd255, 19,  12'd2304, 8'h00, 1'b1, 4'b0100};
    vt[6]  = '{2'b11, 32'h8000_0000, 12'd1024, 8'd255, 3,   12'd1024, 8'd63, 1'b1, 4'b1000};
    vt[7]  = '{2'b11, 32'h8000_0000, 12'd1024, 8'd255, 4,   12'd3072, 8'd191, 1'b1, 4'b1000};
    vt[8]  = '{2'b01, 32'h0040_0000, 12'd0,    8'd128, 514, 12'd2052, 8'h7F, 1'b1, 4'b0010};
    vt[9]  = '{2'b01, 32'h0040_0000, 12'd0,    8'd0,   600, 12'd2396, 8'h00, 1'b1, 4'b0010};
    vt[10] = '{2'b01, 32'h0040_0000, 12'd0,    8'd255, 603, 12'd2408, 8'd210, 1'b1, 4'b0010};
    vt[11] = '{2'b00, 32'h0010_0000, 12'd4095, 8'd255, 3,   12'd1,    8'd254, 1'b1, 4'b0001};
    vt[12] = '{2'b00, 32'hF000_0000, 12'd0,    8'd255, 5,   12'd3072, 8'd223, 1'b1, 4'b0001};

    // Reset state.
    repeat (2) @(negedge sys_clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_lab", wave_lab, 8'h88);

    // Table: load word with en low, then run k cycles and sample.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      wave_sel[1:0]   = vt[i].sel;
      freq_word[31:0] = vt[i].freq;
      phase_off[11:0] = vt[i].off;
      amp[7:0]        = vt[i].amp;
      freq_load = 2'b01;
      @(negedge sys_clk);
      freq_load = 2'b00;
      en = 2'b01;
      repeat (vt[i].k) @(posedge sys_clk);
      @(negedge sys_clk);
      chk($sformatf("vec%0d_addr", i), rom_addr[11:0], vt[i].e_addr);
      chk($sformatf("vec%0d_data", i), data_out[7:0], vt[i].e_data);
      chk($sformatf("vec%0d_valid", i), data_valid[0], vt[i].e_vld);
      chk($sformatf("vec%0d_lab", i), wave_lab[3:0], vt[i].e_lab);
      chk($sformatf("vec%0d_ch1_idle", i), {data_valid[1], data_out[15:8]}, 0);
    end

    // Frequency reload timing, enable drop, clear.
    do_reset();
    wave_sel[1:0] = 2'b00; phase_off[11:0] = 0; amp[7:0] = 8'd255;
    freq_word[31:0] = 32'h0010_0000;
    freq_load = 2'b01;
    @(negedge sys_clk);
    chk("load_en0_addr", rom_addr[11:0], 0);
    freq_load = 2'b00;
    en = 2'b01;
    step_addr0("fl_p2", 12'd0);
    step_addr0("fl_p3", 12'd1);
    step_addr0("fl_p4", 12'd2);
    freq_word[31:0] = 32'h0020_0000;
    freq_load = 2'b01;
    step_addr0("fl_p5_old_step", 12'd3);
    freq_load = 2'b00;
    step_addr0("fl_p6", 12'd4);
    step_addr0("fl_p7_new_step", 12'd6);
    step_addr0("fl_p8", 12'd8);
    en = 2'b00;
    step_addr0("endrop_p9", 12'd10);
    chk("endrop_p9_valid", data_valid[0], 1);
    en = 2'b01;
    step_addr0("endrop_p10_restart", 12'd0);
    chk("endrop_p10_valid", data_valid[0], 1);
    step_addr0("endrop_p11", 12'd2);
    chk("endrop_p11_valid_low", data_valid[0], 0);
    chk("endrop_p11_data_zero", data_out[7:0], 0);
    step_addr0("endrop_p12", 12'd4);
    chk("endrop_p12_valid", data_valid[0], 1);
    clr = 2'b01;
    step_addr0("clr_p13", 12'd6);
    clr = 2'b00;
    step_addr0("clr_p14", 12'd0);
    step_addr0("clr_p15", 12'd2);
    chk("clr_p15_valid", data_valid[0], 1);

    // Two channels, mid-run reset, independent restart, select change.
    do_reset();
    wave_sel = 4'b10_00;
    freq_word = {32'h0800_0000, 32'h0100_0000};
    phase_off = '0;
    amp = 16'hFFFF;
    freq_load = 2'b11;
    @(negedge sys_clk);
    freq_load = 2'b00;
    en = 2'b11;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("two_ch0_data", data_out[7:0], 8'd6);
    chk("two_ch1_data", data_out[15:8], 8'hFE);
    chk("two_ch0_addr", rom_addr[11:0], 12'd144);
    chk("two_ch1_addr", rom_addr[23:12], 12'd1152);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_addr", rom_addr, 0);
    chk("midrst_lab", wave_lab, 8'h88);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    en = 2'b00;
    freq_load = 2'b11;
    @(negedge sys_clk);
    freq_load = 2'b00;
    en = 2'b10;
    @(negedge sys_clk);
    en = 2'b11;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("restart_e3_valid", data_valid, 2'b10);
    chk("restart_e3_data", data_out, 16'hFE00);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("restart_e4_valid", data_valid, 2'b11);
    chk("restart_e4_data", data_out, 16'hFE00);
    chk("restart_e4_addr", rom_addr, {12'd384, 12'd32});
    wave_sel[3:2] = 2'b00;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("sel_e6_lab", wave_lab, 8'b0100_0001);
    chk("sel_e6_data1", data_out[15:8], 8'hFE);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("sel_e7_lab", wave_lab, 8'b0001_0001);
    chk("sel_e7_data1", data_out[15:8], 8'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
